// File: rtl/snake_pattern_gen_pkg.sv
// Shared types, constants and colour/position helpers for the snake animation stage.
package snake_pkg;

  localparam int N_LEDS  = 8;
  localparam int COLOR_W = 24;
  localparam int POS_W   = 3;
  localparam int CH_W    = 8;
  localparam int STEP_W  = 16;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef logic [N_LEDS-1:0][COLOR_W-1:0] frame_arr_t;

  typedef struct packed {
    logic             dir;
    logic [POS_W-1:0] head;
  } head_st_t;

  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch, input int sh);
    logic [CH_W-1:0] res;
    if (sh >= 32'sd8) begin
      res = '0;
    end else begin
      res = ch >> sh;
    end
    return res;
  endfunction

  function automatic logic [COLOR_W-1:0] fade_color(input logic [COLOR_W-1:0] c, input int sh);
    return {fade_ch(c[G_HI:G_LO], sh), fade_ch(c[R_HI:R_LO], sh), fade_ch(c[B_HI:B_LO], sh)};
  endfunction

  // Bounce reflects off the end LEDs; wrap relies on the natural 3-bit roll-over.
  function automatic head_st_t advance_head(input head_st_t cur, input logic bounce);
    head_st_t nxt;
    nxt = cur;
    if (bounce && !cur.dir && (cur.head == 3'd7)) begin
      nxt.dir  = 1'b1;
      nxt.head = 3'd6;
    end else if (bounce && cur.dir && (cur.head == 3'd0)) begin
      nxt.dir  = 1'b0;
      nxt.head = 3'd1;
    end else if (cur.dir) begin
      nxt.head = cur.head - 3'd1;
    end else begin
      nxt.head = cur.head + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/snake_pattern_gen_if.sv
// Control inputs and frame/debug outputs between the snake generator and its neighbours.
interface snake_pattern_gen_if;
  import snake_pkg::*;

  logic               enable;
  logic               bounce_mode;
  logic [COLOR_W-1:0] base_color;
  logic               new_frames_set_rqst;
  logic [COLOR_W-1:0] led0;
  logic [COLOR_W-1:0] led1;
  logic [COLOR_W-1:0] led2;
  logic [COLOR_W-1:0] led3;
  logic [COLOR_W-1:0] led4;
  logic [COLOR_W-1:0] led5;
  logic [COLOR_W-1:0] led6;
  logic [COLOR_W-1:0] led7;
  logic               frames_updated;
  logic [POS_W-1:0]   head_pos_dbg;
  logic               dir_dbg;
  logic [1:0]         state_dbg;

  modport slave (
    input  enable, bounce_mode, base_color, new_frames_set_rqst,
    output led0, led1, led2, led3, led4, led5, led6, led7,
    output frames_updated, head_pos_dbg, dir_dbg, state_dbg
  );

  modport master (
    output enable, bounce_mode, base_color, new_frames_set_rqst,
    input  led0, led1, led2, led3, led4, led5, led6, led7,
    input  frames_updated, head_pos_dbg, dir_dbg, state_dbg
  );

endinterface

// File: rtl/snake_pattern_gen_frame_render.sv
// Combinational renderer: turns head/direction/colour into the eight LED colours.
module snake_frame_render
  import snake_pkg::*;
#(
  parameter int SNAKE_LEN  = 3,
  parameter int FADE_SHIFT = 1
) (
  input  logic [POS_W-1:0]   head_i,
  input  logic               dir_i,
  input  logic               bounce_mode_i,
  input  logic [COLOR_W-1:0] base_color_i,
  input  logic               blank_i,
  output frame_arr_t         frame_o
);

  localparam int POS_EXT_W = POS_W + 3;

  logic signed [POS_EXT_W-1:0] head_ext_s;
  logic signed [POS_EXT_W-1:0] pos_s;
  logic                        hit_s;
  logic [COLOR_W-1:0]          acc_s;

  assign head_ext_s = $signed({3'b000, head_i});

  // Segments are visited tail first so the lowest k claiming an LED is the one kept.
  always_comb begin
    frame_o = '0;
    pos_s   = '0;
    hit_s   = 1'b0;
    acc_s   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      acc_s = '0;
      for (int k = SNAKE_LEN - 1; k >= 0; k--) begin
        pos_s = dir_i ? (head_ext_s + POS_EXT_W'(k)) : (head_ext_s - POS_EXT_W'(k));
        hit_s = bounce_mode_i ? (pos_s == POS_EXT_W'(i))
                              : (pos_s[POS_W-1:0] == POS_W'(i));
        acc_s = hit_s ? fade_color(base_color_i, k * FADE_SHIFT) : acc_s;
      end
      frame_o[i] = blank_i ? '0 : acc_s;
    end
  end

endmodule

// File: rtl/snake_pattern_gen.sv
// Snake animation stage: request edge detect, OFF/RUN/DRAIN sequencing and the
// registered eight-LED frame set handed to the stripe driver.
module snake_pattern_gen
  import snake_pkg::*;
#(
  parameter int SNAKE_LEN   = 3,
  parameter int STEP_FRAMES = 4,
  parameter int FADE_SHIFT  = 1
) (
  input logic               clk,
  input logic               rstn,
  snake_pattern_gen_if.slave bus
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);

  state_e              state_q, state_d;
  logic                rqst_q;
  logic                rq_evt_s;
  head_st_t            pos_q, pos_d, pos_adv_s;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                bounce_q, bounce_d;
  logic                blank_q, blank_d;
  logic                upd_q, upd_d;
  logic                frames_updated_q;
  frame_arr_t          frame_s, led_q;

  assign rq_evt_s  = bus.new_frames_set_rqst & ~rqst_q;
  assign pos_adv_s = advance_head(pos_q, bus.bounce_mode);

  snake_frame_render #(
    .SNAKE_LEN  (SNAKE_LEN),
    .FADE_SHIFT (FADE_SHIFT)
  ) u_render (
    .head_i        (pos_q.head),
    .dir_i         (pos_q.dir),
    .bounce_mode_i (bounce_q),
    .base_color_i  (color_q),
    .blank_i       (blank_q),
    .frame_o       (frame_s)
  );

  // Next-state logic; colour and mode are only picked up when the head moves or the snake starts.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    step_d   = step_q;
    color_d  = color_q;
    bounce_d = bounce_q;
    blank_d  = blank_q;
    upd_d    = rq_evt_s;
    case (state_q)
      ST_OFF: begin
        if (rq_evt_s && bus.enable) begin
          state_d  = ST_RUN;
          pos_d    = '0;
          step_d   = '0;
          color_d  = bus.base_color;
          bounce_d = bus.bounce_mode;
          blank_d  = 1'b0;
        end else if (rq_evt_s) begin
          blank_d = 1'b1;
        end else begin
          blank_d = blank_q;
        end
      end
      ST_RUN: begin
        if (rq_evt_s && !bus.enable) begin
          state_d = ST_DRAIN;
          blank_d = 1'b1;
        end else if (rq_evt_s && (step_q == STEP_LAST)) begin
          step_d   = '0;
          pos_d    = pos_adv_s;
          color_d  = bus.base_color;
          bounce_d = bus.bounce_mode;
          blank_d  = 1'b0;
        end else if (rq_evt_s) begin
          step_d  = step_q + 16'd1;
          blank_d = 1'b0;
        end else begin
          blank_d = blank_q;
        end
      end
      ST_DRAIN: begin
        if (rq_evt_s) begin
          state_d = ST_OFF;
          pos_d   = '0;
          step_d  = '0;
          blank_d = 1'b1;
        end else begin
          blank_d = blank_q;
        end
      end
      default: begin
        state_d = ST_OFF;
        pos_d   = '0;
        step_d  = '0;
        blank_d = 1'b1;
      end
    endcase
  end

  // Control state: cycle 0 of an update updates the snake state, cycle 1 loads the LEDs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_OFF;
      rqst_q   <= 1'b0;
      pos_q    <= '0;
      step_q   <= '0;
      color_q  <= '0;
      bounce_q <= 1'b0;
      blank_q  <= 1'b1;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rqst_q   <= bus.new_frames_set_rqst;
      pos_q    <= pos_d;
      step_q   <= step_d;
      color_q  <= color_d;
      bounce_q <= bounce_d;
      blank_q  <= blank_d;
      upd_q    <= upd_d;
    end
  end

  // Output frame register and its one-cycle update strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_q            <= '0;
      frames_updated_q <= 1'b0;
    end else begin
      if (upd_q) begin
        led_q <= frame_s;
      end
      frames_updated_q <= upd_q;
    end
  end

  assign bus.led0           = led_q[0];
  assign bus.led1           = led_q[1];
  assign bus.led2           = led_q[2];
  assign bus.led3           = led_q[3];
  assign bus.led4           = led_q[4];
  assign bus.led5           = led_q[5];
  assign bus.led6           = led_q[6];
  assign bus.led7           = led_q[7];
  assign bus.frames_updated = frames_updated_q;
  assign bus.head_pos_dbg   = pos_q.head;
  assign bus.dir_dbg        = pos_q.dir;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_snake_pattern_gen.sv
// Bench for snake_pattern_gen: two instances (1 and 4 requests per step) share stimulus
// and are compared against an arithmetic model of the animation.
module tb_snake_pattern_gen;

  localparam int SNAKE_LEN  = 3;
  localparam int FADE_SHIFT = 1;
  localparam int STEP_A     = 1;
  localparam int STEP_B     = 4;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        bounce;
  logic [23:0] color;
  logic        rqst;

  int n_checks = 0;
  int n_pass   = 0;

  snake_pattern_gen_if ifa ();
  snake_pattern_gen_if ifb ();

  assign ifa.enable = enable;
  assign ifa.bounce_mode = bounce;
  assign ifa.base_color = color;
  assign ifa.new_frames_set_rqst = rqst;
  assign ifb.enable = enable;
  assign ifb.bounce_mode = bounce;
  assign ifb.base_color = color;
  assign ifb.new_frames_set_rqst = rqst;

  snake_pattern_gen #(.SNAKE_LEN(SNAKE_LEN), .STEP_FRAMES(STEP_A), .FADE_SHIFT(FADE_SHIFT))
    dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  snake_pattern_gen #(.SNAKE_LEN(SNAKE_LEN), .STEP_FRAMES(STEP_B), .FADE_SHIFT(FADE_SHIFT))
    dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

  logic [23:0] got [2][8];
  always_comb begin
    got[0] = '{ifa.led0, ifa.led1, ifa.led2, ifa.led3, ifa.led4, ifa.led5, ifa.led6, ifa.led7};
    got[1] = '{ifb.led0, ifb.led1, ifb.led2, ifb.led3, ifb.led4, ifb.led5, ifb.led6, ifb.led7};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: mode 0 = off, 1 = running, 2 = draining.
  int          m_mode [2];
  int          m_head [2];
  int          m_dir  [2];
  int          m_step [2];
  int          m_bnc  [2];
  logic [23:0] m_col  [2];
  bit          m_blank[2];
  logic [23:0] exp_led [2][8];
  int          steps  [2] = '{STEP_A, STEP_B};

  function automatic logic [23:0] fade_model(input logic [23:0] c, input int k);
    int sh;
    int div;
    sh  = k * FADE_SHIFT;
    div = 1 << ((sh > 20) ? 20 : sh);
    return {8'(int'(c[23:16]) / div), 8'(int'(c[15:8]) / div), 8'(int'(c[7:0]) / div)};
  endfunction

  task automatic model_render(input int d);
    bit claimed [8];
    int p;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      exp_led[d][i] = 24'h0;
      claimed[i] = 1'b0;
    end
    if (!m_blank[d]) begin
      for (int k = 0; k < SNAKE_LEN; k++) begin
        p  = (m_dir[d] == 1) ? m_head[d] + k : m_head[d] - k;
        ok = 1'b1;
        if (m_bnc[d] == 1) ok = (p >= 0) && (p < 8);
        else p = ((p % 8) + 8) % 8;
        if (ok && !claimed[p]) begin
          exp_led[d][p] = fade_model(m_col[d], k);
          claimed[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_event(input int d);
    case (m_mode[d])
      0: begin
        if (enable) begin
          m_mode[d] = 1; m_head[d] = 0; m_dir[d] = 0; m_step[d] = 0;
          m_col[d] = color; m_bnc[d] = int'(bounce); m_blank[d] = 1'b0;
        end else begin
          m_blank[d] = 1'b1;
        end
      end
      1: begin
        if (!enable) begin
          m_mode[d] = 2; m_blank[d] = 1'b1;
        end else begin
          m_blank[d] = 1'b0;
          m_step[d] = m_step[d] + 1;
          if (m_step[d] == steps[d]) begin
            m_step[d] = 0;
            m_col[d] = color;
            m_bnc[d] = int'(bounce);
            if (m_bnc[d] == 1 && m_dir[d] == 0 && m_head[d] == 7) begin
              m_dir[d] = 1; m_head[d] = 6;
            end else if (m_bnc[d] == 1 && m_dir[d] == 1 && m_head[d] == 0) begin
              m_dir[d] = 0; m_head[d] = 1;
            end else begin
              m_head[d] = (m_head[d] + ((m_dir[d] == 1) ? 7 : 1)) % 8;
            end
          end
        end
      end
      default: begin
        m_mode[d] = 0; m_head[d] = 0; m_dir[d] = 0; m_step[d] = 0; m_blank[d] = 1'b1;
      end
    endcase
    model_render(d);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_head[d] = 0; m_dir[d] = 0; m_step[d] = 0;
      m_bnc[d] = 0; m_col[d] = 24'h0; m_blank[d] = 1'b1;
      model_render(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rqst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One request event; request stays high for max(hold,2) cycles, frames are settled on return.
  task automatic send_req(input int hold);
    @(negedge clk);
    rqst = 1'b1;
    model_event(0);
    model_event(1);
    repeat (2) @(negedge clk);
    for (int i = 2; i < hold; i++) @(negedge clk);
    rqst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b0; bounce = 1'b0; color = 24'h0; rqst = 1'b0; rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[0][i] !== 24'h0) $display("FAIL reset_led%0d: got %h want 000000", i, got[0][i]);
      else n_pass++;
    end
    n_checks++;
    if ({ifa.frames_updated, ifa.head_pos_dbg, ifa.dir_dbg, ifa.state_dbg} !== 7'h0)
      $display("FAIL reset_ctrl: got fu/head/dir/state %b%b%b%b want 0", ifa.frames_updated,
               ifa.head_pos_dbg, ifa.dir_dbg, ifa.state_dbg);
    else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    int cnt;
    enable = 1'b1; bounce = 1'b1; color = 24'hFF0000;
    @(negedge clk);
    rqst = 1'b1;
    model_event(0);
    model_event(1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ifa.frames_updated && cnt < 8);
    n_checks++;
    if (cnt !== 2) $display("FAIL update_latency: strobe after %0d cycles want 2", cnt);
    else n_pass++;
    n_checks++;
    if (ifa.led0 !== 24'hFF0000) $display("FAIL first_led0: got %h want FF0000", ifa.led0);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[0][i] !== exp_led[0][i]) $display("FAIL first_led%0d: got %h want %h", i, got[0][i], exp_led[0][i]);
      else n_pass++;
    end
    rqst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.frames_updated !== 1'b0) $display("FAIL strobe_width: got %b want 0", ifa.frames_updated);
    else n_pass++;
  endtask

  task automatic test_walk();
    repeat (3) send_req(1);
    n_checks++;
    if ({ifa.led3, ifa.led2, ifa.led1} !== {24'hFF0000, 24'h7F0000, 24'h3F0000})
      $display("FAIL walk_tail: got %h %h %h want FF0000 7F0000 3F0000", ifa.led3, ifa.led2, ifa.led1);
    else n_pass++;
    n_checks++;
    if (ifa.head_pos_dbg !== 3'd3) $display("FAIL walk_head: got %0d want 3", ifa.head_pos_dbg);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[0][i] !== exp_led[0][i]) $display("FAIL walk_led%0d: got %h want %h", i, got[0][i], exp_led[0][i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bounce = 1'b0;
    repeat (4) send_req(1);
    n_checks++;
    if (ifa.head_pos_dbg !== 3'd7) $display("FAIL wrap_pre_head: got %0d want 7", ifa.head_pos_dbg);
    else n_pass++;
    send_req(1);
    n_checks++;
    if ({ifa.head_pos_dbg, ifa.led0, ifa.led7, ifa.led6} !== {3'd0, 24'hFF0000, 24'h7F0000, 24'h3F0000})
      $display("FAIL wrap_edge: got head %0d leds %h %h %h want 0 FF0000 7F0000 3F0000",
               ifa.head_pos_dbg, ifa.led0, ifa.led7, ifa.led6);
    else n_pass++;
  endtask

  task automatic test_bounce();
    bounce = 1'b1;
    repeat (7) send_req(1);
    send_req(1);
    n_checks++;
    if ({ifa.head_pos_dbg, ifa.dir_dbg} !== {3'd6, 1'b1})
      $display("FAIL bounce_turn: got head %0d dir %b want 6 1", ifa.head_pos_dbg, ifa.dir_dbg);
    else n_pass++;
    n_checks++;
    if ({ifa.led6, ifa.led7, ifa.led5} !== {24'hFF0000, 24'h7F0000, 24'h000000})
      $display("FAIL bounce_leds: got %h %h %h want FF0000 7F0000 000000", ifa.led6, ifa.led7, ifa.led5);
    else n_pass++;
  endtask

  task automatic test_held_request();
    int pulses;
    do_reset();
    enable = 1'b1; bounce = 1'b0; color = 24'h00FF00;
    send_req(1);
    @(negedge clk);
    rqst = 1'b1;
    model_event(0);
    model_event(1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifb.frames_updated) pulses++;
    end
    rqst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ifb.frames_updated) pulses++;
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL held_one_event: got %0d strobes want 1", pulses);
    else n_pass++;
    for (int p = 0; p < 4; p++) begin
      send_req(1);
      n_checks++;
      if (ifb.head_pos_dbg !== 3'(m_head[1]))
        $display("FAIL held_pulse%0d_head: got %0d want %0d", p, ifb.head_pos_dbg, m_head[1]);
      else n_pass++;
    end
    n_checks++;
    if (ifb.head_pos_dbg !== 3'd1) $display("FAIL held_single_advance: got %0d want 1", ifb.head_pos_dbg);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[1][i] !== exp_led[1][i]) $display("FAIL held_led%0d: got %h want %h", i, got[1][i], exp_led[1][i]);
      else n_pass++;
    end
  endtask

  task automatic test_drain_and_reset();
    enable = 1'b0;
    send_req(1);
    n_checks++;
    if ({ifa.state_dbg, ifa.led0, ifa.led1, ifa.led2, ifa.led3, ifa.led4, ifa.led5, ifa.led6, ifa.led7} !== {2'd2, 192'h0})
      $display("FAIL drain_blank: got state %0d leds %h%h%h%h want 2 and zeros", ifa.state_dbg,
               ifa.led0, ifa.led1, ifa.led2, ifa.led3);
    else n_pass++;
    send_req(1);
    n_checks++;
    if ({ifa.state_dbg, ifa.head_pos_dbg, ifa.dir_dbg} !== {2'd0, 3'd0, 1'b0})
      $display("FAIL drain_off: got state %0d head %0d dir %b want 0 0 0", ifa.state_dbg, ifa.head_pos_dbg, ifa.dir_dbg);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[0][i] !== 24'h0) $display("FAIL off_led%0d: got %h want 000000", i, got[0][i]);
      else n_pass++;
    end
    enable = 1'b1; color = 24'h123456;
    send_req(1);
    @(negedge clk);
    rqst = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[0][i] !== 24'h0) $display("FAIL midreset_led%0d: got %h want 000000", i, got[0][i]);
      else n_pass++;
    end
    @(negedge clk);
    rqst = 1'b0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifa.frames_updated, ifa.led0, ifa.state_dbg} !== {1'b0, 24'h0, 2'd0})
      $display("FAIL midreset_settle: got fu %b led0 %h state %0d want 0 0 0", ifa.frames_updated, ifa.led0, ifa.state_dbg);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      bounce = 1'($urandom_range(0, 1));
      color  = 24'($urandom);
      send_req(int'($urandom_range(1, 4)));
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 8; i++) begin
          n_checks++;
          if (got[d][i] !== exp_led[d][i])
            $display("FAIL rand%0d_dut%0d_led%0d: got %h want %h", n, d, i, got[d][i], exp_led[d][i]);
          else n_pass++;
        end
      end
      n_checks++;
      if ({ifa.head_pos_dbg, ifa.dir_dbg, ifa.state_dbg, ifb.head_pos_dbg, ifb.dir_dbg, ifb.state_dbg} !==
          {3'(m_head[0]), 1'(m_dir[0]), 2'(m_mode[0]), 3'(m_head[1]), 1'(m_dir[1]), 2'(m_mode[1])})
        $display("FAIL rand%0d_ctrl: got a %0d/%b/%0d b %0d/%b/%0d want a %0d/%0d/%0d b %0d/%0d/%0d", n,
                 ifa.head_pos_dbg, ifa.dir_dbg, ifa.state_dbg, ifb.head_pos_dbg, ifb.dir_dbg, ifb.state_dbg,
                 m_head[0], m_dir[0], m_mode[0], m_head[1], m_dir[1], m_mode[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_walk();
    test_wrap();
    test_bounce();
    test_held_request();
    test_drain_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_pattern_gen.md
Name: snake_pattern_gen

Overview:
Upstream animation stage for the LED stripe driver. Produces the eight 24-bit GRB frames (led0..led7) consumed by the stripe top level. Advances a fading "snake" one LED position every STEP_FRAMES frame-set requests. Updates are paced by the driver's new_frames_set_rqst, so a frame set never changes mid-transmission.

Parameters:
SNAKE_LEN, 3, number of lit segments including the head; legal range 1..8.
STEP_FRAMES, 4, number of frame-set requests per head advance; legal range 1..65535.
FADE_SHIFT, 1, right-shift per segment applied to each 8-bit channel (segment k gets channel >> (k*FADE_SHIFT)).

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, asynchronous assert, active-low
enable  in  1  1 = animate; 0 = blank stripe at next request
bounce_mode  in  1  0 = wrap 7->0 / 0->7; 1 = reverse direction at the ends
base_color  in  24  head colour, GRB order, {G[23:16], R[15:8], B[7:0]}
new_frames_set_rqst  in  1  request from the stripe driver; level, rising edge is the event
led0..led7  out  24 each  registered frames for LED 0..7
frames_updated  out  1  one-cycle pulse when led0..led7 take new values
head_pos_dbg  out  3  current head index
dir_dbg  out  1  0 = forward (increasing index), 1 = reverse
state_dbg  out  2  FSM state encoding

Behaviour:
- Reset: led0..led7 = 0, frames_updated = 0, head = 0, dir = 0, step_cnt = 0, state = OFF, rqst edge register = 0.
- Event detection: rq_evt = new_frames_set_rqst & ~rqst_q. A request held high for many cycles is one event.
- Cycle 0 is the edge cycle. Outputs change only at the end of cycle 1 (exactly 1 cycle of latency). frames_updated is high during cycle 2. Outputs are stable otherwise.
- FSM states are OFF, RUN, and DRAIN.
  - OFF: on rq_evt with enable = 1, go to RUN and render frame with head = 0, dir = 0. On rq_evt with enable = 0, output all-zero frames (frames_updated still pulses).
  - RUN: on rq_evt, step_cnt increments.
    - When step_cnt == STEP_FRAMES-1, step_cnt clears and head advances. base_color and bounce_mode are sampled only at this step boundary.
    - Without an advance, the frame is re-rendered with the same head/colour.
  - RUN with enable = 0 at rq_evt: go to DRAIN and output all-zero frames.
  - DRAIN: on the next rq_evt, output zeros again (guarantees the stripe latched blank) and go to OFF; clear head, dir and step_cnt.
- Head advance:
  - Wrap mode: head = head +/- 1 mod 8 (3-bit natural wrap).
  - Bounce mode, dir = 0: at head 7, set dir = 1 and head = 6. Symmetric at head 0.
  - Switching from bounce to wrap keeps the current dir.
- Rendering, for k = 0..SNAKE_LEN-1:
  - Segment position p = head - k (dir = 0) or head + k (dir = 1).
  - Segment colour: each channel of base_color >> (k*FADE_SHIFT), saturating to 0 when the shift is >= 8.
  - Wrap mode: p is taken mod 8.
  - Bounce mode: segments with p outside 0..7 are not drawn.
  - Undrawn LEDs = 0. If two segments map to one LED, the lower k wins.
- Simultaneous events: rq_evt coincident with reset is ignored. An enable change within the 2-cycle update window takes effect at the next rq_evt.
- Reset mid-update: outputs return to 0 immediately, with no partial frame set.
- Width rules: step_cnt is 16 bits. Compare against STEP_FRAMES-1 with unsigned arithmetic.

Decomposition:
- Package snake_pkg:
  - N_LEDS = 8, COLOR_W = 24, POS_W = 3.
  - State enum {ST_OFF = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2}.
  - GRB channel slice constants.
- Sub-module snake_frame_render: purely combinational.
  - Inputs: head, dir, bounce_mode, base_color, blank.
  - Output: 8x24 frame array.
  - Parent registers it in cycle 1.
- The FSM, edge detect and counters live in snake_pattern_gen.

Test Plan:
1. Reset then enable = 1, base_color = 24'hFF0000, SNAKE_LEN = 3, STEP_FRAMES = 1, one request -> led0 = 24'hFF0000, all other LEDs 0. frames_updated pulses 2 cycles after the edge.
2. Same setup, 3 more requests -> head = 3: led3 = FF0000, led2 = 7F0000, led1 = 3F0000, others 0.
3. Wrap mode, STEP_FRAMES = 1, head at 7, one request -> head = 0: led0 = FF0000, led7 = 7F0000, led6 = 3F0000.
4. bounce_mode = 1, head at 7, one request -> head = 6, dir_dbg = 1: led6 = FF0000, led7 = 7F0000, led5 = 0.
5. STEP_FRAMES = 4, request held high 100 cycles then 4 separate pulses -> the held request counts as 1 event. head advances exactly once, on the 4th event.
6. Mid-run, enable = 0 -> next request gives all zeros and state DRAIN. Following request gives zeros and state OFF, head = 0. Assert rstn = 0 between requests -> all outputs 0 within the same cycle.
